// File: rtl/boot_config_loader.sv
// boot_config_loader: power-on reset generator and boot configuration loader.
// After reset, the loader holds the core in reset for POR_CYCLES cycles.
// It then reads NBYTES bytes from the SRAM window at BASE_ADDR into a shadow
// register. On the last byte it publishes the whole word to cfg in one
// update and releases pwon_reset_n.
// Optional build macro BOOTCFG_MAGIC_CHECK_EN: a signature byte (MAGIC) is
// expected at BASE_ADDR. On a mismatch the loader falls back to DEFAULTS.
//
// state        | meaning
// ST_POR_WAIT  | core held in reset, power-on counter running, loader owns bus
// ST_MAGIC     | reading signature byte at BASE_ADDR (macro builds only)
// ST_READ      | reading configuration byte r_idx into the shadow register
// ST_DONE      | cfg published, core released, bus handed back to the core
module boot_config_loader #(
  parameter int                   NBYTES        = 4,
  parameter int                   ADDR_W        = 21,
  parameter logic [ADDR_W-1:0]    BASE_ADDR     = 21'h008000,
  parameter int                   POR_CYCLES    = 1024,
  parameter int                   SETTLE_CYCLES = 2,
  parameter logic [NBYTES*8-1:0]  DEFAULTS      = '0,
  parameter logic [7:0]           MAGIC         = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reload,
  output logic [ADDR_W-1:0]     sram_addr,
  input  logic [7:0]            sram_data_in,
  output logic                  sram_we_n,
  output logic                  bus_own,
  output logic                  pwon_reset_n,
  output logic [NBYTES*8-1:0]   cfg,
  output logic                  cfg_loaded,
  output logic                  busy
);

  localparam int                CW          = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam logic [CW-1:0]     POR_LAST    = CW'(POR_CYCLES - 1);
  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [3:0]        IDX_LAST    = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    ST_POR_WAIT = 2'd0,
    ST_MAGIC    = 2'd1,
    ST_READ     = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                r_state,   w_state_nxt;
  logic [CW-1:0]         r_por_cnt, w_por_cnt_nxt;
  logic [3:0]            r_settle,  w_settle_nxt;
  logic [3:0]            r_idx,     w_idx_nxt;
  logic [ADDR_W-1:0]     r_addr,    w_addr_nxt;
  logic [NBYTES*8-1:0]   r_shadow,  w_shadow_nxt;
  logic [NBYTES*8-1:0]   r_cfg,     w_cfg_nxt;
  logic                  r_loaded,  w_loaded_nxt;
  logic                  r_pwon_n,  w_pwon_n_nxt;
  logic                  r_bus_own, w_bus_own_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  w_access_end;

  // State and output registers; rst restarts the whole sequence and drops the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_POR_WAIT;
      r_por_cnt <= '0;
      r_settle  <= '0;
      r_idx     <= '0;
      r_addr    <= BASE_ADDR;
      r_shadow  <= '0;
      r_cfg     <= DEFAULTS;
      r_loaded  <= 1'b0;
      r_pwon_n  <= 1'b0;
      r_bus_own <= 1'b1;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_por_cnt <= w_por_cnt_nxt;
      r_settle  <= w_settle_nxt;
      r_idx     <= w_idx_nxt;
      r_addr    <= w_addr_nxt;
      r_shadow  <= w_shadow_nxt;
      r_cfg     <= w_cfg_nxt;
      r_loaded  <= w_loaded_nxt;
      r_pwon_n  <= w_pwon_n_nxt;
      r_bus_own <= w_bus_own_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic; every output is computed here and registered above.
  always_comb begin
    w_state_nxt   = r_state;
    w_por_cnt_nxt = r_por_cnt;
    w_settle_nxt  = r_settle;
    w_idx_nxt     = r_idx;
    w_addr_nxt    = r_addr;
    w_shadow_nxt  = r_shadow;
    w_cfg_nxt     = r_cfg;
    w_loaded_nxt  = r_loaded;
    w_pwon_n_nxt  = r_pwon_n;
    w_bus_own_nxt = r_bus_own;
    w_busy_nxt    = r_busy;
    w_access_end  = (r_settle == SETTLE_LAST);

    case (r_state)
      ST_POR_WAIT: begin
        if (r_por_cnt == POR_LAST) begin
          w_por_cnt_nxt = '0;
          w_settle_nxt  = '0;
          w_idx_nxt     = '0;
`ifdef BOOTCFG_MAGIC_CHECK_EN
          w_state_nxt   = ST_MAGIC;
`else
          w_state_nxt   = ST_READ;
`endif
        end else begin
          w_por_cnt_nxt = r_por_cnt + CW'(1);
        end
      end

`ifdef BOOTCFG_MAGIC_CHECK_EN
      ST_MAGIC: begin
        if (w_access_end) begin
          w_settle_nxt = '0;
          if (sram_data_in == MAGIC) begin
            w_state_nxt = ST_READ;
            w_addr_nxt  = r_addr + ADDR_W'(1);
          end else begin
            w_state_nxt   = ST_DONE;
            w_cfg_nxt     = DEFAULTS;
            w_loaded_nxt  = 1'b0;
            w_pwon_n_nxt  = 1'b1;
            w_bus_own_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
          end
        end else begin
          w_settle_nxt = r_settle + 4'd1;
        end
      end
`endif

      ST_READ: begin
        if (w_access_end) begin
          w_settle_nxt = '0;
          w_shadow_nxt[{r_idx, 3'b000} +: 8] = sram_data_in;
          if (r_idx == IDX_LAST) begin
            // Publish the shadow including the byte sampled on this edge.
            w_state_nxt   = ST_DONE;
            w_cfg_nxt     = w_shadow_nxt;
            w_loaded_nxt  = 1'b1;
            w_pwon_n_nxt  = 1'b1;
            w_bus_own_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
          end else begin
            w_idx_nxt  = r_idx + 4'd1;
            w_addr_nxt = r_addr + ADDR_W'(1);
          end
        end else begin
          w_settle_nxt = r_settle + 4'd1;
        end
      end

      ST_DONE: begin
        // cfg and cfg_loaded hold their values across a reload until the next publish.
        if (reload) begin
          w_state_nxt   = ST_POR_WAIT;
          w_por_cnt_nxt = '0;
          w_settle_nxt  = '0;
          w_idx_nxt     = '0;
          w_addr_nxt    = BASE_ADDR;
          w_pwon_n_nxt  = 1'b0;
          w_bus_own_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_POR_WAIT;
      end
    endcase
  end

  assign sram_addr    = r_addr;
  assign sram_we_n    = 1'b1;
  assign bus_own      = r_bus_own;
  assign pwon_reset_n = r_pwon_n;
  assign cfg          = r_cfg;
  assign cfg_loaded   = r_loaded;
  assign busy         = r_busy;

endmodule

// File: tb/tb_boot_config_loader.sv
// Bench for boot_config_loader. It runs two instances: u0 with the default
// window and timing, and u1 with a window that wraps at the top of the
// address space. The bench follows BOOTCFG_MAGIC_CHECK_EN when that macro is
// defined for the build.
module tb_boot_config_loader;

`ifdef BOOTCFG_MAGIC_CHECK_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif

  localparam logic [20:0] BASE0 = 21'h008000;
  localparam int          POR0  = 1024;
  localparam int          S0    = 2;
  localparam logic [31:0] DEF0  = 32'hDEADBEEF;
  localparam int          L0    = POR0 + (4 + M) * (S0 + 1);

  localparam logic [20:0] BASE1 = 21'h1FFFFE;
  localparam int          POR1  = 16;
  localparam int          S1    = 0;
  localparam logic [31:0] DEF1  = 32'h0;
  localparam int          L1    = POR1 + (4 + M) * (S1 + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0 = 1'b1, rst1 = 1'b1, rl0 = 1'b0, rl1 = 1'b0;
  logic [20:0] a0, a1;
  logic [7:0]  d0, d1;
  logic        we0, we1, own0, own1, pw0, pw1, ld0, ld1, bz0, bz1;
  logic [31:0] c0, c1;
  logic [7:0]  mem0 [8];
  logic [7:0]  mem1 [8];
  logic [20:0] off0, off1;

  boot_config_loader #(.NBYTES(4), .ADDR_W(21), .BASE_ADDR(BASE0), .POR_CYCLES(POR0),
    .SETTLE_CYCLES(S0), .DEFAULTS(DEF0), .MAGIC(8'hA5)) u0 (
    .clk(clk), .rst(rst0), .reload(rl0), .sram_addr(a0), .sram_data_in(d0),
    .sram_we_n(we0), .bus_own(own0), .pwon_reset_n(pw0), .cfg(c0),
    .cfg_loaded(ld0), .busy(bz0));

  boot_config_loader #(.NBYTES(4), .ADDR_W(21), .BASE_ADDR(BASE1), .POR_CYCLES(POR1),
    .SETTLE_CYCLES(S1), .DEFAULTS(DEF1), .MAGIC(8'hA5)) u1 (
    .clk(clk), .rst(rst1), .reload(rl1), .sram_addr(a1), .sram_data_in(d1),
    .sram_we_n(we1), .bus_own(own1), .pwon_reset_n(pw1), .cfg(c1),
    .cfg_loaded(ld1), .busy(bz1));

  // Asynchronous-read SRAM models; addresses outside the 8-byte window read EE.
  always_comb begin
    off0 = a0 - BASE0;
    off1 = a1 - BASE1;
    d0 = (off0 < 21'd8) ? mem0[off0[2:0]] : 8'hEE;
    d1 = (off1 < 21'd8) ? mem1[off1[2:0]] : 8'hEE;
  end

  // Selects which instance the generic checks observe.
  logic        sel = 1'b0;
  logic [20:0] m_addr;
  logic [31:0] m_cfg;
  logic        m_pw, m_own, m_bz, m_ld, m_we;
  assign m_addr = sel ? a1   : a0;
  assign m_cfg  = sel ? c1   : c0;
  assign m_pw   = sel ? pw1  : pw0;
  assign m_own  = sel ? own1 : own0;
  assign m_bz   = sel ? bz1  : bz0;
  assign m_ld   = sel ? ld1  : ld0;
  assign m_we   = sel ? we1  : we0;

  typedef struct {
    logic [31:0] cfg;
    logic        loaded;
    int          lat;
    logic [31:0] held;
    logic        held_loaded;
    int          naddr;
  } exp_t;

  exp_t        sb[$];
  logic [20:0] addr_q[$];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] cfg, input logic loaded, input int lat,
                          input logic [31:0] held, input logic held_loaded,
                          input logic [20:0] base, input int naddr);
    exp_t e;
    e.cfg = cfg; e.loaded = loaded; e.lat = lat;
    e.held = held; e.held_loaded = held_loaded; e.naddr = naddr;
    sb.push_back(e);
    for (int j = 0; j < naddr; j++) addr_q.push_back(base + 21'(j));
  endtask

  task automatic check_reset(input logic [20:0] base, input logic [31:0] defs);
    check("rst_pwon_n", m_pw, 1'b0);
    check("rst_bus_own", m_own, 1'b1);
    check("rst_busy", m_bz, 1'b1);
    check("rst_we_n", m_we, 1'b1);
    check("rst_addr", m_addr, base);
    check("rst_cfg", m_cfg, defs);
    check("rst_loaded", m_ld, 1'b0);
  endtask

  // n0 is the number of edges already elapsed since the start edge.
  task automatic wait_done(input int n0);
    exp_t        e;
    logic [20:0] seen[$];
    logic [20:0] ea;
    logic        held_ok, we_ok;
    int          n;
    e = sb.pop_front();
    held_ok = 1'b1;
    we_ok   = 1'b1;
    seen.push_back(m_addr);
    n = n0;
    while (m_pw !== 1'b1 && n < e.lat + 40) begin
      @(posedge clk); #1;
      n++;
      if (m_we !== 1'b1) we_ok = 1'b0;
      if (m_pw !== 1'b1) begin
        if (m_cfg !== e.held || m_ld !== e.held_loaded) held_ok = 1'b0;
        if (m_own !== 1'b1 || m_bz !== 1'b1) held_ok = 1'b0;
        if (m_addr !== seen[$]) seen.push_back(m_addr);
      end
    end
    check("latency", n, e.lat);
    check("cfg", m_cfg, e.cfg);
    check("cfg_loaded", m_ld, e.loaded);
    check("done_bus_own", m_own, 1'b0);
    check("done_busy", m_bz, 1'b0);
    check("cfg_held_during_load", held_ok, 1'b1);
    check("we_n_inactive", we_ok, 1'b1);
    check("addr_count", seen.size(), e.naddr);
    for (int i = 0; i < e.naddr; i++) begin
      ea = addr_q.pop_front();
      check("addr_seq", (i < seen.size()) ? seen[i] : 21'h0, ea);
    end
  endtask

  task automatic do_reload();
    rl0 = 1'b1;
    @(posedge clk); #1;
    rl0 = 1'b0;
    check("reload_pwon_low", m_pw, 1'b0);
    check("reload_bus_own", m_own, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mem0[i] = 8'hEE;
      mem1[i] = 8'hEE;
    end
    mem0[0] = 8'hA5;
    mem1[0] = 8'hA5;
    mem0[M+0] = 8'h11; mem0[M+1] = 8'h22; mem0[M+2] = 8'h33; mem0[M+3] = 8'h44;
    mem1[M+0] = 8'h01; mem1[M+1] = 8'h02; mem1[M+2] = 8'h03; mem1[M+3] = 8'h04;

    // Plain load (or magic OK) on u0.
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    check_reset(BASE0, DEF0);
    push_exp(32'h44332211, 1'b1, L0, DEF0, 1'b0, BASE0, 4 + M);
    wait_done(0);

    // Reload with new SRAM contents; a second pulse during POR_WAIT is ignored.
    mem0[M+0] = 8'hAA; mem0[M+1] = 8'hBB; mem0[M+2] = 8'hCC; mem0[M+3] = 8'hDD;
    push_exp(32'hDDCCBBAA, 1'b1, L0, 32'h44332211, 1'b1, BASE0, 4 + M);
    do_reload();
    rl0 = 1'b1;
    @(posedge clk); #1;
    rl0 = 1'b0;
    wait_done(1);

`ifdef BOOTCFG_MAGIC_CHECK_EN
    // Signature mismatch falls back to DEFAULTS after a single access.
    mem0[0] = 8'h5A;
    push_exp(DEF0, 1'b0, POR0 + S0 + 1, 32'hDDCCBBAA, 1'b1, BASE0, 1);
    do_reload();
    wait_done(0);
    mem0[0] = 8'hA5;
    check("magic_bad_reload_steady", m_cfg, DEF0);
`endif

    // Reset during byte 2, then a full rerun.
    begin
      logic [31:0] prev_cfg;
      prev_cfg = (M == 1) ? DEF0 : 32'hDDCCBBAA;
      do_reload();
      repeat (POR0 + (M + 2) * (S0 + 1)) @(posedge clk);
      #1;
      check("midread_addr", m_addr, BASE0 + 21'(M + 2));
      check("midread_cfg_unchanged", m_cfg, prev_cfg);
      rst0 = 1'b1;
      @(posedge clk); #1;
      rst0 = 1'b0;
      check_reset(BASE0, DEF0);
      push_exp(32'hDDCCBBAA, 1'b1, L0, DEF0, 1'b0, BASE0, 4 + M);
      wait_done(0);
    end

    // Address wrap on u1.
    sel = 1'b1;
    @(posedge clk); #1;
    check_reset(BASE1, DEF1);
    @(posedge clk); #1;
    rst1 = 1'b0;
    push_exp(32'h04030201, 1'b1, L1, DEF1, 1'b0, BASE1, 4 + M);
    wait_done(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boot_config_loader.md
# boot_config_loader

Power-on reset generator and multi-byte boot configuration loader that sits between the board clocking and the machine core, sharing the external SRAM bus with the core. After reset it holds the core in reset, waits a fixed settle time, and reads `NBYTES` configuration bytes from a fixed SRAM window. It then presents them as a packed configuration word and releases the core reset. It generalises the single-purpose configuration retriever: it has a configurable byte count and timing, optional validity checking, and a run-time reload that re-resets the machine.

## Interface
Parameters:
- `NBYTES`, 4 — number of configuration bytes read (1..16).
- `ADDR_W`, 21 — SRAM address width.
- `BASE_ADDR`, 21'h008000 — SRAM address of the first byte of the window.
- `POR_CYCLES`, 1024 — clock cycles of reset hold before the first read (≥1).
- `SETTLE_CYCLES`, 2 — extra SRAM access wait cycles per byte (0..15).
- `DEFAULTS`, {NBYTES{8'h00}} — `NBYTES*8`-bit fallback configuration.
- `MAGIC`, 8'hA5 — expected signature byte; used only with `BOOTCFG_MAGIC_CHECK_EN`.

Ports:
- `clk` in 1 — system clock.
- `rst` in 1 — synchronous reset, active-high.
- `reload` in 1 — single-cycle request to re-run the load sequence.
- `sram_addr` out `ADDR_W` — SRAM address while the loader owns the bus.
- `sram_data_in` in 8 — SRAM read data.
- `sram_we_n` out 1 — tied inactive (1); the loader never writes.
- `bus_own` out 1 — 1 while the loader drives the SRAM bus; the top level muxes the address to the core when 0.
- `pwon_reset_n` out 1 — active-low reset to the machine core.
- `cfg` out `NBYTES*8` — configuration word; byte i sits at bits [8i+7:8i].
- `cfg_loaded` out 1 — 1 when `cfg` came from SRAM; 0 when `cfg` holds `DEFAULTS`.
- `busy` out 1 — 1 in any state other than DONE.

## Operation
- States: POR_WAIT → READ → DONE. With magic check enabled, a MAGIC state runs between POR_WAIT and READ.
- **POR_WAIT**
  - Cycle counter runs from 0 to `POR_CYCLES-1`.
  - `bus_own`=1 and `pwon_reset_n`=0.
- **MAGIC**
  - Drives `BASE_ADDR` and samples one byte.
  - Match with `MAGIC` → READ.
  - Mismatch → DONE with `cfg`=`DEFAULTS` and `cfg_loaded`=0.
- **READ**
  - Byte index k runs from 0 to `NBYTES-1`. Address is `BASE_ADDR + OFS + k`, where `OFS`=1 with magic check and 0 without. Address arithmetic is `ADDR_W` bits wide and wraps modulo 2^`ADDR_W`.
  - Each byte is captured into a shadow register, not into `cfg`.
  - After the last byte → DONE.
- **DONE**
  - `cfg` takes the shadow register in a single-cycle atomic update, and `cfg_loaded`=1. `cfg` never shows a partial load.
  - `pwon_reset_n`=1, `bus_own`=0, `busy`=0.
  - `reload`=1 → POR_WAIT: `pwon_reset_n` drops, `bus_own` rises, and `cfg`/`cfg_loaded` keep their previous values until the next DONE entry.
- `reload` is ignored outside DONE. It is not queued.
- `rst` has priority over everything. It restarts POR_WAIT from count 0 from any state, including mid-read, and discards the shadow contents.

## Timing
- Reset values:
  - `pwon_reset_n`=0, `bus_own`=1, `busy`=1, `sram_we_n`=1.
  - `sram_addr`=`BASE_ADDR`, `cfg`=`DEFAULTS`, `cfg_loaded`=0.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Byte access:
  - `sram_addr` is valid from the first cycle of the access.
  - Data is sampled at the clock edge ending cycle `SETTLE_CYCLES` of that access, so each byte occupies `SETTLE_CYCLES+1` cycles.
  - `sram_addr` changes only at access boundaries.
- Latency from the first cycle with `rst`=0 to `pwon_reset_n`=1: `POR_CYCLES + (NBYTES+M)*(SETTLE_CYCLES+1)`. `M`=1 with magic check and 0 without.
- Magic mismatch latency: `POR_CYCLES + (SETTLE_CYCLES+1)`.
- `pwon_reset_n`, `bus_own`, `busy`, `cfg` and `cfg_loaded` change on the same edge (the DONE entry).
- `reload` sampled in DONE: `pwon_reset_n`=0 on the following edge. The same latency as above then applies, counted from that edge.

## Configuration
- `BOOTCFG_MAGIC_CHECK_EN` defined:
  - The MAGIC state is present; the window is `MAGIC` followed by `NBYTES` bytes.
  - A mismatch loads `DEFAULTS` with `cfg_loaded`=0.
- Undefined:
  - No MAGIC state; bytes start at `BASE_ADDR`.
  - `cfg_loaded`=1 after every completed load.
  - The `MAGIC` parameter is unused.

## Test plan
- **Plain load**: defaults, macro off, SRAM[8000..8003]=11,22,33,44.
  - `pwon_reset_n` rises exactly 1024+4*3=1036 cycles after `rst` falls.
  - `cfg`=32'h44332211 and `cfg_loaded`=1.
- **Magic OK**: macro on, SRAM[8000]=A5, [8001..8004]=01,02,03,04.
  - `cfg`=32'h04030201 and `cfg_loaded`=1.
  - Rise occurs at 1039 cycles.
- **Magic bad**: macro on, SRAM[8000]=5A, `DEFAULTS`=32'hDEADBEEF.
  - `cfg`=DEADBEEF and `cfg_loaded`=0.
  - Rise occurs at 1027 cycles, and only address 8000 is driven.
- **Reload**: after a load with SRAM=11,22,33,44, change SRAM to AA,BB,CC,DD and pulse `reload`.
  - `pwon_reset_n`=0 the next cycle.
  - `cfg` holds 44332211 until the new DONE entry, then becomes DDCCBBAA.
  - A `reload` pulse during POR_WAIT has no effect.
- **Mid-read reset**: assert `rst` during byte 2.
  - All outputs return to their reset values.
  - The full sequence reruns with exact latency, and no partial `cfg` is ever observed.
- **Address wrap**: `ADDR_W`=21, `BASE_ADDR`=21'h1FFFFE, `NBYTES`=4.
  - Addresses driven are 1FFFFE, 1FFFFF, 000000, 000001.
  - `sram_we_n`=1 throughout.
